// File: rtl/alu_pkg.sv
// Opcodes, FSM state encoding and opcode classification shared by the ALU slice.
// Pure declarations; no timing.
// No flow control.
package alu_pkg;

    localparam logic [4:0] OP_ADD    = 5'h00;
    localparam logic [4:0] OP_SUB    = 5'h01;
    localparam logic [4:0] OP_XOR    = 5'h02;
    localparam logic [4:0] OP_OR     = 5'h03;
    localparam logic [4:0] OP_AND    = 5'h04;
    localparam logic [4:0] OP_SLL    = 5'h05;
    localparam logic [4:0] OP_SRL    = 5'h06;
    localparam logic [4:0] OP_SRA    = 5'h07;
    localparam logic [4:0] OP_SLTU   = 5'h08;
    localparam logic [4:0] OP_SLT    = 5'h09;
    localparam logic [4:0] OP_PASSB  = 5'h0A;
    localparam logic [4:0] OP_MUL    = 5'h10;
    localparam logic [4:0] OP_MULH   = 5'h11;
    localparam logic [4:0] OP_MULHSU = 5'h12;
    localparam logic [4:0] OP_MULHU  = 5'h13;
    localparam logic [4:0] OP_DIV    = 5'h14;
    localparam logic [4:0] OP_DIVU   = 5'h15;
    localparam logic [4:0] OP_REM    = 5'h16;
    localparam logic [4:0] OP_REMU   = 5'h17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The M set occupies 0x10-0x17 exactly.
    function automatic logic is_muldiv(input logic [4:0] op);
        return op[4:3] == 2'b10;
    endfunction

endpackage

// File: rtl/alu_seq_md_if.sv
// Operation/result handshake bundle between operand stage, ALU and writeback.
// Wires only; no latency.
// Carries in_valid/in_ready and out_valid/out_ready pairs plus flush.
interface alu_seq_md_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output flush, in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  flush, in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider over a 2*XLEN accumulator.
// XLEN steps after start; last is high during the final step, acc_nxt holds its outcome.
// No backpressure; abort stops the sequence immediately.
module muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              abort,
    input  logic              start,
    input  logic              is_div,
    input  logic [XLEN-1:0]   opa,
    input  logic [XLEN-1:0]   opb,
    output logic              last,
    output logic [2*XLEN-1:0] acc_nxt
);
    localparam int SHW = $clog2(XLEN);

    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   dvs;
    logic [SHW-1:0]    cnt;
    logic              run;
    logic              div_q;
    logic [XLEN:0]     sum;
    logic [XLEN:0]     part;
    logic [XLEN:0]     trial;

    // Multiply: acc = {partial, multiplier}. Divide: acc = {remainder, quotient}.
    always_comb begin
        sum     = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, dvs};
        part    = acc[2*XLEN-1:XLEN-1];
        trial   = part - {1'b0, dvs};
        acc_nxt = acc;
        if (div_q) begin
            if (trial[XLEN])
                acc_nxt = {part[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            else
                acc_nxt = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else if (acc[0]) begin
            acc_nxt = {sum, acc[XLEN-1:1]};
        end else begin
            acc_nxt = {1'b0, acc[2*XLEN-1:1]};
        end
    end

    assign last = run && (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            dvs   <= '0;
            cnt   <= '0;
            run   <= 1'b0;
            div_q <= 1'b0;
        end else if (abort) begin
            run <= 1'b0;
        end else if (start) begin
            acc   <= {{XLEN{1'b0}}, opa};
            dvs   <= opb;
            div_q <= is_div;
            cnt   <= SHW'(XLEN - 1);
            run   <= 1'b1;
        end else if (run) begin
            acc <= acc_nxt;
            cnt <= cnt - SHW'(1);
            if (cnt == '0)
                run <= 1'b0;
        end
    end
endmodule

// File: rtl/alu_seq_md.sv
// RV32I ALU with iterative RV32M multiply/divide behind a valid/ready handshake.
// Base ops: result 1 cycle after accept; M ops: XLEN+1 cycles after accept.
// Result held until out_ready; one op in flight, in_ready only while idle.
module alu_seq_md
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_seq_md_if.slave  bus
);
    localparam int SHW = $clog2(XLEN);

    state_t            state, state_nxt;
    logic              accept;
    logic              md_op;
    logic [XLEN-1:0]   base_res;
    logic [SHW-1:0]    shamt;
    logic              a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [4:0]        op_q;
    logic              neg_q, rem_neg_q, dz_q, ovf_q;
    logic [XLEN-1:0]   a_q;
    logic              md_last;
    logic [2*XLEN-1:0] acc_nxt;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, md_res;

    assign bus.in_ready = (state == ST_IDLE);
    assign bus.busy     = (state == ST_CALC);
    assign accept       = bus.in_valid && (state == ST_IDLE) && !bus.flush;
    assign md_op        = is_muldiv(bus.op);
    assign shamt        = bus.b[SHW-1:0];

    always_comb begin
        base_res = '0;
        case (bus.op)
            OP_ADD:   base_res = bus.a + bus.b;
            OP_SUB:   base_res = bus.a - bus.b;
            OP_XOR:   base_res = bus.a ^ bus.b;
            OP_OR:    base_res = bus.a | bus.b;
            OP_AND:   base_res = bus.a & bus.b;
            OP_SLL:   base_res = bus.a << shamt;
            OP_SRL:   base_res = bus.a >> shamt;
            OP_SRA:   base_res = $unsigned($signed(bus.a) >>> shamt);
            OP_SLTU:  base_res = XLEN'(bus.a < bus.b);
            OP_SLT:   base_res = XLEN'($signed(bus.a) < $signed(bus.b));
            OP_PASSB: base_res = bus.b;
            default:  base_res = '0;
        endcase
    end

    // MUL takes its low half unsigned: the low product bits do not depend on signedness.
    always_comb begin
        a_sgn = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                (bus.op == OP_DIV)  || (bus.op == OP_REM);
        b_sgn = (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM);
        a_neg = a_sgn && bus.a[XLEN-1];
        b_neg = b_sgn && bus.b[XLEN-1];
        a_mag = a_neg ? -bus.a : bus.a;
        b_mag = b_neg ? -bus.b : bus.b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
            a_q       <= '0;
        end else if (accept && md_op) begin
            op_q      <= bus.op;
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            dz_q      <= (bus.b == '0);
            ovf_q     <= ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                         (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == '1);
            a_q       <= bus.a;
        end
    end

    muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk     (clk),
        .rst_n   (rst_n),
        .abort   (bus.flush),
        .start   (accept && md_op),
        .is_div  (bus.op[2]),
        .opa     (a_mag),
        .opb     (b_mag),
        .last    (md_last),
        .acc_nxt (acc_nxt)
    );

    // Sign fix-up and special cases, applied to the final iteration's value.
    always_comb begin
        prod   = neg_q ? -acc_nxt : acc_nxt;
        quo    = acc_nxt[XLEN-1:0];
        rem    = acc_nxt[2*XLEN-1:XLEN];
        md_res = '0;
        case (op_q)
            OP_MUL:                        md_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  md_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU: begin
                if (dz_q)       md_res = '1;
                else if (ovf_q) md_res = a_q;
                else            md_res = neg_q ? -quo : quo;
            end
            OP_REM, OP_REMU: begin
                if (dz_q)       md_res = a_q;
                else if (ovf_q) md_res = '0;
                else            md_res = rem_neg_q ? -rem : rem;
            end
            default:                       md_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (accept)        state_nxt = md_op ? ST_CALC : ST_DONE;
                ST_CALC: if (md_last)       state_nxt = ST_DONE;
                ST_DONE: if (bus.out_ready) state_nxt = ST_IDLE;
                default:                    state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.result    <= '0;
            bus.out_valid <= 1'b0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
        end else if (accept && !md_op) begin
            bus.result    <= base_res;
            bus.out_valid <= 1'b1;
        end else if ((state == ST_CALC) && md_last) begin
            bus.result    <= md_res;
            bus.out_valid <= 1'b1;
        end else if ((state == ST_DONE) && bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_seq_md.sv
// Scoreboard bench for alu_seq_md: reference model results queued at issue, compared at out_valid.
module tb_alu_seq_md;
    import alu_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_seq_md_if #(.XLEN(32)) bus();

    alu_seq_md #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_chk = 0;
    int          n_bad = 0;
    logic [31:0] sb_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [4:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
        logic signed [63:0] sx, sy, ux, uy, p;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'd0, x};
        uy = {32'd0, y};
        p  = '0;
        case (o)
            OP_ADD:    return x + y;
            OP_SUB:    return x - y;
            OP_XOR:    return x ^ y;
            OP_OR:     return x | y;
            OP_AND:    return x & y;
            OP_SLL:    return x << y[4:0];
            OP_SRL:    return x >> y[4:0];
            OP_SRA:    return $unsigned($signed(x) >>> y[4:0]);
            OP_SLTU:   return (x < y) ? 32'd1 : 32'd0;
            OP_SLT:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            OP_PASSB:  return y;
            OP_MUL:    begin p = sx * sy; return p[31:0];  end
            OP_MULH:   begin p = sx * sy; return p[63:32]; end
            OP_MULHSU: begin p = sx * uy; return p[63:32]; end
            OP_MULHU:  begin p = ux * uy; return p[63:32]; end
            OP_DIV:    begin if (y == 0) return '1; p = sx / sy; return p[31:0]; end
            OP_DIVU:   begin if (y == 0) return '1; p = ux / uy; return p[31:0]; end
            OP_REM:    begin if (y == 0) return x;  p = sx % sy; return p[31:0]; end
            OP_REMU:   begin if (y == 0) return x;  p = ux % uy; return p[31:0]; end
            default:   return 32'd0;
        endcase
    endfunction

    // Called just after a rising edge; returns just after the accepting edge with inputs scrambled.
    task automatic drive(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        bus.op       = o;
        bus.a        = x;
        bus.b        = y;
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("accept_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op       = 5'($urandom);
        bus.a        = $urandom;
        bus.b        = $urandom;
    endtask

    task automatic run_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int hold);
        int          lat;
        logic [31:0] exp_r;
        sb_q.push_back(ref_alu(o, x, y));
        bus.out_ready = (hold == 0);
        drive(o, x, y);
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            if (lat == 10) begin
                chk("calc_in_ready", bus.in_ready, 0);
                chk("calc_busy", bus.busy, 1);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        chk($sformatf("latency op%0h", o), lat, is_muldiv(o) ? 33 : 1);
        exp_r = sb_q.pop_front();
        chk($sformatf("result op%0h a=%0h b=%0h", o, x, y), bus.result, exp_r);
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        if (hold > 0) begin
            chk("hold_result", bus.result, exp_r);
            chk("hold_out_valid", bus.out_valid, 1);
            chk("hold_in_ready", bus.in_ready, 0);
            bus.out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("post_out_valid", bus.out_valid, 0);
        chk("post_in_ready", bus.in_ready, 1);
    endtask

    logic [4:0] op_tab [21] = '{OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND, OP_SLL, OP_SRL,
                                OP_SRA, OP_SLTU, OP_SLT, OP_PASSB, OP_MUL, OP_MULH,
                                OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
                                5'h0B, 5'h1F};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic seen;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        #2;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        #20 rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(OP_ADD,    32'h7FFFFFFF, 32'h1, 0);
        run_op(OP_SRA,    32'h80000000, 32'h24, 0);
        run_op(OP_MULH,   32'hFFFFFFFE, 32'h3, 0);
        run_op(OP_MUL,    32'hFFFFFFFE, 32'h3, 0);
        run_op(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op(OP_MULHSU, 32'hFFFFFFFE, 32'hFFFFFFFF, 0);
        run_op(OP_DIV,    32'h7, 32'hFFFFFFFE, 0);
        run_op(OP_REM,    32'h7, 32'hFFFFFFFE, 0);
        run_op(OP_DIVU,   32'h5, 32'h0, 0);
        run_op(OP_REMU,   32'h5, 32'h0, 0);
        run_op(OP_DIV,    32'hFFFFFFF9, 32'h0, 0);
        run_op(OP_REM,    32'hFFFFFFF9, 32'h0, 0);
        run_op(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 0);
        run_op(OP_REM,    32'h80000000, 32'hFFFFFFFF, 0);
        run_op(OP_SLT,    32'hFFFFFFFF, 32'h1, 0);
        run_op(OP_SLTU,   32'hFFFFFFFF, 32'h1, 0);
        run_op(5'h0C,     32'h1234, 32'h5678, 0);
        run_op(OP_DIVU,   32'd1000, 32'd7, 10);

        for (int i = 0; i < 20; i++)
            run_op(op_tab[$urandom_range(0, 20)], $urandom, $urandom, 0);

        // Flush mid-calculation.
        drive(OP_DIV, 32'd100, 32'd7);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        chk("flush_in_ready", bus.in_ready, 1);
        chk("flush_busy", bus.busy, 0);
        chk("flush_out_valid", bus.out_valid, 0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        chk("flush_no_result", seen, 0);

        // Flush beats a simultaneous accept.
        bus.op       = OP_ADD;
        bus.a        = 32'd1;
        bus.b        = 32'd1;
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            if (bus.out_valid || bus.busy) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("flush_blocks_accept", seen, 0);

        // Reset mid-calculation.
        drive(OP_MUL, 32'h12345678, 32'h9ABCDEF0);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_result", bus.result, 0);
        chk("arst_busy", bus.busy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(OP_ADD, 32'd2, 32'd3, 0);
        chk("sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
